// File: rtl/sample_iter_if.sv
// Bus between the bounding-box stage (R13), the sample iterator and the
// downstream jitter/sample test (R14).
interface sample_iter_if #(
  parameter int SIGFIG  = 24,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
);
  // Handshake: a triangle transfers on a rising clk edge where
  // validTri_R13H && !halt_R13H; the producer holds its data while halted.
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U;
  logic [1:0][1:0][SIGFIG-1:0]            box_R13S;
  logic                                   validTri_R13H;
  logic [3:0]                             subSample_R13U;
  logic                                   halt_R13H;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
  logic [COLORS-1:0][SIGFIG-1:0]          color_R14U;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0]    sample_R14S;
  logic [SAMPLES-1:0]                     validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_R13U,
    input  halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_R13U,
    output halt_R13H, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_iter.sv
// Walks a triangle's bounding box row-major, emitting SAMPLES sample points per cycle.
// Optional counters enabled by defining SAMPLE_ITER_STATS_EN.
module sample_iter #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int VERTS   = 3,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 2
) (
  input  logic clk,
  input  logic rst,
  sample_iter_if.slave bus,
  output logic state_dbg
`ifdef SAMPLE_ITER_STATS_EN
  ,
  output logic [31:0] tri_count_R14U,
  output logic [31:0] samp_count_R14U
`endif
);
  typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;

  localparam logic signed [SIGFIG-1:0] STEP_1X  = SIGFIG'(1 << RADIX);
  localparam logic signed [SIGFIG-1:0] STEP_4X  = SIGFIG'(1 << (RADIX - 1));
  localparam logic signed [SIGFIG-1:0] STEP_16X = SIGFIG'(1 << (RADIX - 2));
  localparam logic signed [SIGFIG-1:0] STEP_64X = SIGFIG'(1 << (RADIX - 3));

  state_t state;
  logic signed [SIGFIG-1:0] cur_x, cur_y, ll_x, ur_x, ur_y, step;
  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;

  logic signed [SIGFIG-1:0] in_llx, in_lly, in_urx, in_ury, step_in;
  logic signed [SIGFIG-1:0] lx, next_x;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0] samp;
  logic [SAMPLES-1:0] samp_valid;
  logic row_end, last, halt, transfer, degenerate;

  assign in_llx = $signed(bus.box_R13S[0][0]);
  assign in_lly = $signed(bus.box_R13S[0][1]);
  assign in_urx = $signed(bus.box_R13S[1][0]);
  assign in_ury = $signed(bus.box_R13S[1][1]);
  assign degenerate = (in_urx < in_llx) || (in_ury < in_lly);

  always_comb begin
    unique case (bus.subSample_R13U)
      4'b0100: step_in = STEP_4X;
      4'b0010: step_in = STEP_16X;
      4'b0001: step_in = STEP_64X;
      default: step_in = STEP_1X;
    endcase
  end

  // Lanes are spaced by step; the running sum past the last lane is the next cur_x.
  always_comb begin
    lx         = cur_x;
    samp       = '0;
    samp_valid = '0;
    for (int k = 0; k < SAMPLES; k++) begin
      if (state == TEST) begin
        samp[k][0]    = lx;
        samp[k][1]    = cur_y;
        samp_valid[k] = (lx <= ur_x);
      end
      lx = lx + step;
    end
    next_x = lx;
  end

  assign row_end  = next_x > ur_x;
  assign last     = (state == TEST) && row_end && ((cur_y + step) > ur_y);
  assign halt     = (state == TEST) && !last;
  assign transfer = bus.validTri_R13H && !halt;

  assign bus.halt_R13H      = halt;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = samp;
  assign bus.validSamp_R14H = samp_valid;
  assign state_dbg          = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= WAIT;
      cur_x   <= '0;
      cur_y   <= '0;
      ll_x    <= '0;
      ur_x    <= '0;
      ur_y    <= '0;
      step    <= '0;
      tri_q   <= '0;
      color_q <= '0;
    end else if (state == WAIT || last) begin
      // Degenerate boxes are consumed without producing samples.
      if (transfer && !degenerate) begin
        state   <= TEST;
        tri_q   <= bus.tri_R13S;
        color_q <= bus.color_R13U;
        ll_x    <= in_llx;
        ur_x    <= in_urx;
        ur_y    <= in_ury;
        step    <= step_in;
        cur_x   <= in_llx;
        cur_y   <= in_lly;
      end else begin
        state <= WAIT;
      end
    end else if (row_end) begin
      cur_x <= ll_x;
      cur_y <= cur_y + step;
    end else begin
      cur_x <= next_x;
    end
  end

`ifdef SAMPLE_ITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_count_R14U  <= '0;
      samp_count_R14U <= '0;
    end else begin
      if (transfer && !degenerate) tri_count_R14U <= tri_count_R14U + 32'd1;
      samp_count_R14U <= samp_count_R14U + 32'($countones(samp_valid));
    end
  end
`endif
endmodule

// File: tb/tb_sample_iter.sv
// Directed bench for sample_iter: box walks, row ends, back-to-back, resets.
module tb_sample_iter;
  localparam int SIGFIG  = 24;
  localparam int VERTS   = 3;
  localparam int AXIS    = 3;
  localparam int COLORS  = 3;
  localparam int SAMPLES = 2;

  logic clk = 1'b0;
  logic rst;
  logic state_dbg;
`ifdef SAMPLE_ITER_STATS_EN
  logic [31:0] tri_count, samp_count;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_iter_if #(.SIGFIG(SIGFIG), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS),
                   .SAMPLES(SAMPLES)) bus ();

  sample_iter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .state_dbg(state_dbg)
`ifdef SAMPLE_ITER_STATS_EN
    ,
    .tri_count_R14U(tri_count),
    .samp_count_R14U(samp_count)
`endif
  );

  function automatic logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_pat(input int seed);
    logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] t;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        t[v][a] = SIGFIG'(seed * 100 + v * 10 + a);
    return t;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_tri(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] sub, input int seed);
    bus.tri_R13S       = tri_pat(seed);
    for (int c = 0; c < COLORS; c++) bus.color_R13U[c] = SIGFIG'(seed + c);
    bus.box_R13S[0][0] = SIGFIG'(llx);
    bus.box_R13S[0][1] = SIGFIG'(lly);
    bus.box_R13S[1][0] = SIGFIG'(urx);
    bus.box_R13S[1][1] = SIGFIG'(ury);
    bus.subSample_R13U = sub;
    bus.validTri_R13H  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.validTri_R13H  = 1'b0;
    bus.tri_R13S       = '0;
    bus.color_R13U     = '0;
    bus.box_R13S       = '0;
    bus.subSample_R13U = 4'b1000;
    tick();
    tick();
    checks++;
    if (bus.halt_R13H !== 1'b0 || bus.validSamp_R14H !== 2'b00 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: halt=%b valid=%b state=%b, want 0 00 0",
               bus.halt_R13H, bus.validSamp_R14H, state_dbg);
    end
    checks++;
    if (bus.tri_R14S !== '0 || bus.color_R14U !== '0 || bus.sample_R14S !== '0) begin
      errors++;
      $display("FAIL reset_data: tri=%h color=%h samp=%h, want all 0",
               bus.tri_R14S, bus.color_R14U, bus.sample_R14S);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_walk_1x();
    int ex[4];
    int ey[4];
    ex = '{0, 2048, 0, 2048};
    ey = '{0, 0, 1024, 1024};
    drive_tri(0, 0, 3072, 1024, 4'b1000, 1);
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.tri_R14S !== tri_pat(1) || bus.color_R14U[1] !== SIGFIG'(2)) begin
      errors++;
      $display("FAIL walk_latch: tri=%h color=%h", bus.tri_R14S, bus.color_R14U);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.sample_R14S[0][0] !== SIGFIG'(ex[c]) || bus.sample_R14S[0][1] !== SIGFIG'(ey[c]) ||
          bus.sample_R14S[1][0] !== SIGFIG'(ex[c] + 1024) || bus.sample_R14S[1][1] !== SIGFIG'(ey[c])) begin
        errors++;
        $display("FAIL walk_samp c%0d: got (%0d,%0d)/(%0d,%0d) want (%0d,%0d)/(%0d,%0d)", c,
                 bus.sample_R14S[0][0], bus.sample_R14S[0][1], bus.sample_R14S[1][0],
                 bus.sample_R14S[1][1], ex[c], ey[c], ex[c] + 1024, ey[c]);
      end
      checks++;
      if (bus.validSamp_R14H !== 2'b11) begin
        errors++;
        $display("FAIL walk_valid c%0d: got %b want 11", c, bus.validSamp_R14H);
      end
      checks++;
      if (bus.halt_R13H !== 1'(c < 3)) begin
        errors++;
        $display("FAIL walk_halt c%0d: got %b want %b", c, bus.halt_R13H, 1'(c < 3));
      end
      tick();
    end
    checks++;
    if (state_dbg !== 1'b0 || bus.validSamp_R14H !== 2'b00) begin
      errors++;
      $display("FAIL walk_done: state=%b valid=%b want 0 00", state_dbg, bus.validSamp_R14H);
    end
  endtask

  task automatic test_row_end();
    drive_tri(0, 0, 2048, 0, 4'b1000, 2);
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.validSamp_R14H !== 2'b11 || bus.sample_R14S[1][0] !== SIGFIG'(1024) ||
        bus.halt_R13H !== 1'b1) begin
      errors++;
      $display("FAIL rowend_c1: valid=%b x1=%0d halt=%b want 11 1024 1",
               bus.validSamp_R14H, bus.sample_R14S[1][0], bus.halt_R13H);
    end
    tick();
    checks++;
    if (bus.validSamp_R14H !== 2'b01 || bus.sample_R14S[0][0] !== SIGFIG'(2048) ||
        bus.sample_R14S[1][0] !== SIGFIG'(3072) || bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL rowend_c2: valid=%b x0=%0d x1=%0d halt=%b want 01 2048 3072 0",
               bus.validSamp_R14H, bus.sample_R14S[0][0], bus.sample_R14S[1][0], bus.halt_R13H);
    end
    tick();
    checks++;
    if (state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL rowend_wait: state=%b want 0", state_dbg);
    end
  endtask

  task automatic test_single_point();
    drive_tri(5120, 5120, 5120, 5120, 4'b1000, 3);
    checks++;
    if (bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL point_halt_pre: got %b want 0", bus.halt_R13H);
    end
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.validSamp_R14H !== 2'b01 || bus.halt_R13H !== 1'b0 ||
        bus.sample_R14S[0][0] !== SIGFIG'(5120) || bus.sample_R14S[0][1] !== SIGFIG'(5120)) begin
      errors++;
      $display("FAIL point_c1: valid=%b halt=%b s0=(%0d,%0d) want 01 0 (5120,5120)",
               bus.validSamp_R14H, bus.halt_R13H, bus.sample_R14S[0][0], bus.sample_R14S[0][1]);
    end
    tick();
    checks++;
    if (state_dbg !== 1'b0 || bus.validSamp_R14H !== 2'b00) begin
      errors++;
      $display("FAIL point_done: state=%b valid=%b want 0 00", state_dbg, bus.validSamp_R14H);
    end
  endtask

  task automatic test_back_to_back();
    drive_tri(0, 0, 512, 512, 4'b0100, 4);
    tick();
    drive_tri(1024, 2048, 2048, 2048, 4'b1000, 6);
    checks++;
    if (bus.sample_R14S[1][0] !== SIGFIG'(512) || bus.sample_R14S[0][1] !== SIGFIG'(0) ||
        bus.validSamp_R14H !== 2'b11 || bus.halt_R13H !== 1'b1) begin
      errors++;
      $display("FAIL b2b_a1: x1=%0d y=%0d valid=%b halt=%b want 512 0 11 1",
               bus.sample_R14S[1][0], bus.sample_R14S[0][1], bus.validSamp_R14H, bus.halt_R13H);
    end
    tick();
    checks++;
    if (bus.sample_R14S[0][0] !== SIGFIG'(0) || bus.sample_R14S[0][1] !== SIGFIG'(512) ||
        bus.validSamp_R14H !== 2'b11 || bus.halt_R13H !== 1'b0 || bus.tri_R14S !== tri_pat(4)) begin
      errors++;
      $display("FAIL b2b_a2: s0=(%0d,%0d) valid=%b halt=%b want (0,512) 11 0",
               bus.sample_R14S[0][0], bus.sample_R14S[0][1], bus.validSamp_R14H, bus.halt_R13H);
    end
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (state_dbg !== 1'b1 || bus.sample_R14S[0][0] !== SIGFIG'(1024) ||
        bus.sample_R14S[1][0] !== SIGFIG'(2048) || bus.sample_R14S[0][1] !== SIGFIG'(2048) ||
        bus.validSamp_R14H !== 2'b11 || bus.tri_R14S !== tri_pat(6)) begin
      errors++;
      $display("FAIL b2b_b1: state=%b x0=%0d x1=%0d y=%0d valid=%b want 1 1024 2048 2048 11",
               state_dbg, bus.sample_R14S[0][0], bus.sample_R14S[1][0], bus.sample_R14S[0][1],
               bus.validSamp_R14H);
    end
    tick();
    checks++;
    if (state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: state=%b want 0", state_dbg);
    end
  endtask

  task automatic test_reset_mid();
    drive_tri(0, 0, 3072, 1024, 4'b1000, 7);
    tick();
    bus.validTri_R13H = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.validSamp_R14H !== 2'b00 || bus.sample_R14S !== '0 || bus.tri_R14S !== '0 ||
        bus.halt_R13H !== 1'b0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b samp=%h tri=%h halt=%b state=%b want all 0",
               bus.validSamp_R14H, bus.sample_R14S, bus.tri_R14S, bus.halt_R13H, state_dbg);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 1'b0 || bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL midrst_wait: state=%b halt=%b want 0 0", state_dbg, bus.halt_R13H);
    end
    drive_tri(3072, 1024, 4096, 1024, 4'b1000, 8);
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.sample_R14S[0][0] !== SIGFIG'(3072) || bus.sample_R14S[0][1] !== SIGFIG'(1024) ||
        bus.sample_R14S[1][0] !== SIGFIG'(4096) || bus.validSamp_R14H !== 2'b11 ||
        bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL midrst_next: s0=(%0d,%0d) x1=%0d valid=%b halt=%b want (3072,1024) 4096 11 0",
               bus.sample_R14S[0][0], bus.sample_R14S[0][1], bus.sample_R14S[1][0],
               bus.validSamp_R14H, bus.halt_R13H);
    end
    tick();
  endtask

  task automatic test_bad_subsample();
    drive_tri(0, 0, 1024, 0, 4'b0110, 9);
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (bus.sample_R14S[1][0] !== SIGFIG'(1024) || bus.validSamp_R14H !== 2'b11 ||
        bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL badsub: x1=%0d valid=%b halt=%b want 1024 11 0",
               bus.sample_R14S[1][0], bus.validSamp_R14H, bus.halt_R13H);
    end
    tick();
  endtask

  task automatic test_degenerate();
`ifdef SAMPLE_ITER_STATS_EN
    logic [31:0] tri_before;
    tri_before = tri_count;
`endif
    drive_tri(1024, 0, 0, 0, 4'b1000, 10);
    checks++;
    if (bus.halt_R13H !== 1'b0) begin
      errors++;
      $display("FAIL degen_halt: got %b want 0", bus.halt_R13H);
    end
    tick();
    bus.validTri_R13H = 1'b0;
    checks++;
    if (state_dbg !== 1'b0 || bus.validSamp_R14H !== 2'b00) begin
      errors++;
      $display("FAIL degen_drop: state=%b valid=%b want 0 00", state_dbg, bus.validSamp_R14H);
    end
    tick();
    checks++;
    if (bus.validSamp_R14H !== 2'b00) begin
      errors++;
      $display("FAIL degen_idle: valid=%b want 00", bus.validSamp_R14H);
    end
`ifdef SAMPLE_ITER_STATS_EN
    checks++;
    if (tri_count !== tri_before) begin
      errors++;
      $display("FAIL degen_count: got %0d want %0d", tri_count, tri_before);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_walk_1x();
    test_row_end();
    test_single_point();
    test_back_to_back();
    test_reset_mid();
    test_bad_subsample();
    test_degenerate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sample_iter.md
Name: sample_iter

Overview:
- Sample-generation stage that feeds the sample test.
- Accepts one triangle per handshake from the bounding-box stage, together with its bounding box, color and MSAA rate.
- Walks the box in row-major order and emits SAMPLES sample locations per cycle, with per-lane valid flags, on the R14 interface consumed downstream by jitter/sample test.
- Backpressures the bounding-box stage while a box is being walked.

Parameters:
SIGFIG, 24, bits in color and position
RADIX, 10, fraction bits in position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels
SAMPLES, 2, sample lanes emitted per cycle (power of 2, 1..8)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
tri_R13S  in  SIGFIG x VERTS x AXIS, signed  triangle vertices
color_R13U  in  SIGFIG x COLORS, unsigned  triangle color
box_R13S  in  SIGFIG x 2 x 2, signed  [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y
validTri_R13H  in  1  triangle/box valid
subSample_R13U  in  4  MSAA rate, one-hot: 1000=1x, 0100=4x, 0010=16x, 0001=64x
halt_R13H  out  1  high = not accepting; transfer occurs when validTri_R13H && !halt_R13H
tri_R14S  out  SIGFIG x VERTS x AXIS  latched triangle
color_R14U  out  SIGFIG x COLORS  latched color
sample_R14S  out  SIGFIG x SAMPLES x 2  per-lane sample (x,y)
validSamp_R14H  out  SAMPLES  per-lane sample valid

Behaviour:
- Step size is latched at accept: 1x=1<<RADIX, 4x=1<<(RADIX-1), 16x=1<<(RADIX-2), 64x=1<<(RADIX-3). A non-one-hot subSample is treated as 1x.
- FSM states are WAIT and TEST.
- WAIT:
  - halt_R13H=0 and all validSamp_R14H=0.
  - On transfer with urx>=llx and ury>=lly: latch tri, color, box and step; set cur=(llx,lly); go to TEST.
  - On transfer with a degenerate box (urx<llx or ury<lly): the triangle is dropped and the FSM stays in WAIT.
- TEST (each cycle):
  - Lane k drives x=cur_x+k*step, y=cur_y, validSamp[k]=(x<=urx).
  - Lane 0 is always valid.
  - row_end = cur_x+SAMPLES*step > urx.
  - last = row_end && (cur_y+step > ury).
  - Next cur: if !row_end, cur_x += SAMPLES*step; else if !last, (llx, cur_y+step).
  - Next state: on last, go to WAIT, unless a new transfer occurs in the same cycle.
- halt_R13H = (state==TEST) && !last, combinational from registered state.
  - A new triangle may be accepted in the final TEST cycle; it begins emitting on the next cycle with zero bubbles.
  - A degenerate box accepted in the final TEST cycle leads to WAIT.
- Latency: transfer at edge N produces the first samples in cycle N+1.
- Registered outputs are tri_R14S, color_R14U and the sample/valid lanes, derived from registered cur. No combinational path exists from R13 inputs to R14 outputs.
- Throughput: ceil((W/step+1)/SAMPLES) cycles per row × (H/step+1) rows.
- Arithmetic:
  - Signed SIGFIG.
  - The box is guaranteed on-screen by upstream, so x+SAMPLES*step never overflows.
  - The lower-left corner is used exactly as given, with no snapping.
- Reset (asserted at any time, including mid-box):
  - Asynchronously sets state=WAIT, halt_R13H=0, validSamp=0, and all data outputs and cur/box registers to 0.
  - The box in progress is abandoned.
- subSample and box changes while in TEST are ignored until the next transfer.

Optional Feature:
- Macro SAMPLE_ITER_STATS_EN adds output ports tri_count_R14U[31:0] and samp_count_R14U[31:0].
  - tri_count increments per non-degenerate accepted triangle.
  - samp_count adds popcount(validSamp_R14H) each cycle.
  - Both counters wrap at 2^32 and reset to 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- 1x, box (0,0)-(3072,1024), SAMPLES=2:
  - 4 TEST cycles, emitting lane pairs (0,0)/(1024,0), (2048,0)/(3072,0), (0,1024)/(1024,1024), (2048,1024)/(3072,1024), all valid.
  - halt_R13H is high for the first 3 cycles.
- 1x, box (0,0)-(2048,0):
  - cycle 1 lanes (0,0),(1024,0) are both valid.
  - cycle 2 lane0 (2048,0) is valid; lane1 (3072,0) is invalid.
  - FSM returns to WAIT.
- Box (5120,5120)-(5120,5120):
  - one TEST cycle with lane0 valid and lane1 invalid.
  - halt_R13H never goes high.
- Back-to-back: tri A at 4x with box (0,0)-(512,512), then tri B held valid:
  - A emits 2 cycles (step 512).
  - B is accepted in A's last cycle, and B's samples appear on the following cycle with no idle cycle.
- Reset low during the 2nd cycle of scenario 1:
  - outputs go to 0 and validSamp to 0 immediately.
  - After release, FSM is in WAIT with halt=0, and the next triangle walks from its own lower-left corner.
- Degenerate box (1024,0)-(0,0) with valid=1:
  - accepted (halt stays 0), no valid samples are emitted, and with SAMPLE_ITER_STATS_EN tri_count is unchanged.
